mem_req_queue: RTL and testbench

MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

---
 rtl/mem_req_queue.sv | 107 ++++++++++
 tb/tb_mem_req_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// Request queue between a core and the secondary port of a memory arbiter.
// Buffers core requests in FIFO order, retries the head while the arbiter denies it, and flags read returns.
module mem_req_queue #(
  parameter int PORTW     = 32,
  parameter int ADDRWIDTH = 15,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTW-1:0]         d_in,
  input  logic [ADDRWIDTH-1:0]     addr_in,
  input  logic                     en_in_x,
  input  logic                     wr_in_x,
  input  logic [PORTW-1:0]         bit_wr_in_x,
  output logic                     stall,
  output logic [PORTW-1:0]         d,
  output logic [ADDRWIDTH-1:0]     addr,
  output logic                     en_x,
  output logic                     wr_x,
  output logic [PORTW-1:0]         bit_wr_x,
  input  logic                     mem_busy,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int LVLW = PTRW + 1;
  localparam logic [LVLW-1:0] FULL_LVL = LVLW'(DEPTH);

  logic [PORTW-1:0]     d_mem    [DEPTH];
  logic [ADDRWIDTH-1:0] addr_mem [DEPTH];
  logic                 wr_mem   [DEPTH];
  logic [PORTW-1:0]     bwr_mem  [DEPTH];

  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0] level_q, level_d;
  logic            rd_valid_q, rd_valid_d;

  logic full, empty, push, pop;

  // Push sees only the registered level, so a full queue refuses even when a pop frees a slot this edge.
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign push  = !en_in_x && !full;
  assign pop   = !empty && !mem_busy;

  // NOTE: every variable gets a default first so no path through always_comb can infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_valid_d = pop && wr_mem[rd_ptr_q];
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // NOTE: storage is deliberately not reset; level_q gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      d_mem[wr_ptr_q]    <= d_in;
      addr_mem[wr_ptr_q] <= addr_in;
      wr_mem[wr_ptr_q]   <= wr_in_x;
      bwr_mem[wr_ptr_q]  <= bit_wr_in_x;
    end
  end

  always_comb begin
    en_x     = 1'b1;
    wr_x     = 1'b1;
    bit_wr_x = '1;
    d        = '0;
    addr     = '0;
    if (!empty) begin
      en_x     = 1'b0;
      wr_x     = wr_mem[rd_ptr_q];
      bit_wr_x = bwr_mem[rd_ptr_q];
      d        = d_mem[rd_ptr_q];
      addr     = addr_mem[rd_ptr_q];
    end
  end

  assign stall    = full;
  assign rd_valid = rd_valid_q;
  assign level    = level_q;

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: single write, contended read, fill/stall, wrap and mid-cycle reset.
module tb_mem_req_queue;

  localparam int PORTW     = 32;
  localparam int ADDRWIDTH = 15;
  localparam int DEPTH     = 4;
  localparam int LVLW      = $clog2(DEPTH) + 1;

  logic                 clk;
  logic                 rst;
  logic [PORTW-1:0]     d_in;
  logic [ADDRWIDTH-1:0] addr_in;
  logic                 en_in_x;
  logic                 wr_in_x;
  logic [PORTW-1:0]     bit_wr_in_x;
  logic                 stall;
  logic [PORTW-1:0]     d;
  logic [ADDRWIDTH-1:0] addr;
  logic                 en_x;
  logic                 wr_x;
  logic [PORTW-1:0]     bit_wr_x;
  logic                 mem_busy;
  logic                 rd_valid;
  logic [LVLW-1:0]      level;

  int checks = 0;
  int errors = 0;

  mem_req_queue #(.PORTW(PORTW), .ADDRWIDTH(ADDRWIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .d_in       (d_in),
    .addr_in    (addr_in),
    .en_in_x    (en_in_x),
    .wr_in_x    (wr_in_x),
    .bit_wr_in_x(bit_wr_in_x),
    .stall      (stall),
    .d          (d),
    .addr       (addr),
    .en_x       (en_x),
    .wr_x       (wr_x),
    .bit_wr_x   (bit_wr_x),
    .mem_busy   (mem_busy),
    .rd_valid   (rd_valid),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [ADDRWIDTH-1:0] a, input logic [PORTW-1:0] dv,
                           input logic wr_n, input logic [PORTW-1:0] mask_n);
    en_in_x     = 1'b0;
    addr_in     = a;
    d_in        = dv;
    wr_in_x     = wr_n;
    bit_wr_in_x = mask_n;
  endtask

  task automatic idle_req();
    en_in_x     = 1'b1;
    wr_in_x     = 1'b1;
    bit_wr_in_x = '1;
    addr_in     = '0;
    d_in        = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en_x"},     64'(en_x),     64'd1);
    check({tag, "_wr_x"},     64'(wr_x),     64'd1);
    check({tag, "_bit_wr_x"}, 64'(bit_wr_x), 64'hFFFF_FFFF);
    check({tag, "_d"},        64'(d),        64'd0);
    check({tag, "_addr"},     64'(addr),     64'd0);
    check({tag, "_level"},    64'(level),    64'd0);
    check({tag, "_stall"},    64'(stall),    64'd0);
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    mem_busy = 1'b0;
    idle_req();

    // Reset state, before and after a clock edge while rst is held
    #2;
    check_idle("rst_early");
    tick();
    check_idle("rst_edge");

    // Single write; rst falls mid-cycle and the first edge after it must accept the push
    #2;
    rst = 1'b0;
    drive_req(15'h0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_FFFF);
    #1;
    check("wr1_no_bypass", 64'(en_x), 64'd1);
    tick();
    idle_req();
    check("wr1_en_x",     64'(en_x),     64'd0);
    check("wr1_addr",     64'(addr),     64'h10);
    check("wr1_d",        64'(d),        64'hDEAD_BEEF);
    check("wr1_wr_x",     64'(wr_x),     64'd0);
    check("wr1_bit_wr_x", 64'(bit_wr_x), 64'h0000_FFFF);
    check("wr1_level",    64'(level),    64'd1);
    tick();
    check("wr1_pop_level", 64'(level),    64'd0);
    check("wr1_pop_en_x",  64'(en_x),     64'd1);
    check("wr1_rd_valid",  64'(rd_valid), 64'd0);
    tick();
    check("wr1_rd_valid2", 64'(rd_valid), 64'd0);

    // Contended read at 0x0005: denied for 3 cycles, head presented 4 cycles, then one pop
    mem_busy = 1'b1;
    drive_req(15'h0005, 32'h0, 1'b1, '1);
    tick();
    idle_req();
    check("rd_push_en_x", 64'(en_x), 64'd0);
    check("rd_push_addr", 64'(addr), 64'h5);
    check("rd_push_wr_x", 64'(wr_x), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rd_hold%0d_en_x", i),     64'(en_x),     64'd0);
      check($sformatf("rd_hold%0d_addr", i),     64'(addr),     64'h5);
      check($sformatf("rd_hold%0d_level", i),    64'(level),    64'd1);
      check($sformatf("rd_hold%0d_rd_valid", i), 64'(rd_valid), 64'd0);
    end
    mem_busy = 1'b0;
    tick();
    check("rd_pop_level",    64'(level),    64'd0);
    check("rd_pop_en_x",     64'(en_x),     64'd1);
    check("rd_pop_rd_valid", 64'(rd_valid), 64'd1);
    tick();
    check("rd_after_rd_valid", 64'(rd_valid), 64'd0);

    // Fill to DEPTH with the arbiter busy; entry 2 is a read
    mem_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(ADDRWIDTH'(32'h100 + i), PORTW'(32'hA0 + i), (i == 2), '0);
      tick();
      check($sformatf("fill%0d_level", i), 64'(level), 64'(i + 1));
      check($sformatf("fill%0d_head", i),  64'(addr),  64'h100);
    end
    check("fill_stall", 64'(stall), 64'd1);
    // Fifth request refused while full; core keeps it asserted
    drive_req(15'h0104, 32'hA4, 1'b0, '0);
    tick();
    check("full_refuse_level", 64'(level), 64'd4);
    check("full_refuse_stall", 64'(stall), 64'd1);
    check("full_refuse_head",  64'(addr),  64'h100);
    // Full with simultaneous push and pop: pop only
    mem_busy = 1'b0;
    tick();
    check("full_pp_level", 64'(level), 64'd3);
    check("full_pp_stall", 64'(stall), 64'd0);
    check("full_pp_head",  64'(addr),  64'h101);
    // Held fifth request is now accepted alongside a pop
    tick();
    idle_req();
    check("push5_level",    64'(level),    64'd3);
    check("push5_head",     64'(addr),     64'h102);
    check("push5_wr_x",     64'(wr_x),     64'd1);
    check("push5_rd_valid", 64'(rd_valid), 64'd0);
    tick();
    check("drain2_level",    64'(level),    64'd2);
    check("drain2_head",     64'(addr),     64'h103);
    check("drain2_rd_valid", 64'(rd_valid), 64'd1);
    tick();
    check("drain3_level",    64'(level),    64'd1);
    check("drain3_head",     64'(addr),     64'h104);
    check("drain3_d",        64'(d),        64'hA4);
    check("drain3_rd_valid", 64'(rd_valid), 64'd0);
    tick();
    check("drain4_level", 64'(level), 64'd0);
    check("drain4_en_x",  64'(en_x),  64'd1);

    // Wrap: 10 back-to-back writes, each issued the cycle after its push
    for (int k = 0; k < 10; k++) begin
      drive_req(ADDRWIDTH'(k), PORTW'(32'hC000 + k), 1'b0, '0);
      tick();
      check($sformatf("wrap%0d_en_x", k),  64'(en_x),  64'd0);
      check($sformatf("wrap%0d_addr", k),  64'(addr),  64'(k));
      check($sformatf("wrap%0d_d", k),     64'(d),     64'(32'hC000 + k));
      check($sformatf("wrap%0d_level", k), 64'(level), 64'd1);
    end
    idle_req();
    tick();
    check("wrap_end_level", 64'(level), 64'd0);
    check("wrap_end_en_x",  64'(en_x),  64'd1);

    // Mid-operation reset with level=3 and an rd_valid pulse pending
    mem_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(ADDRWIDTH'(32'h20 + i), '0, 1'b1, '1);
      tick();
    end
    idle_req();
    mem_busy = 1'b0;
    tick();
    check("pre_rst_level",    64'(level),    64'd3);
    check("pre_rst_rd_valid", 64'(rd_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check_idle("mid_rst");
    #2;
    rst = 1'b0;
    drive_req(15'h0033, 32'h1234_5678, 1'b0, '0);
    tick();
    idle_req();
    check("post_rst_level", 64'(level), 64'd1);
    check("post_rst_addr",  64'(addr),  64'h33);
    check("post_rst_d",     64'(d),     64'h1234_5678);
    check("post_rst_en_x",  64'(en_x),  64'd0);
    tick();
    check("post_rst_drain", 64'(level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
